// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the block memory reader.
package mem_rd_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int DIM_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/mem_block_addr_gen.sv
// Walks a 2-D block in raster order. It holds the column and row counters and
// the current row base. It provides the address of the following element and
// flags when the current element is the final one.
module mem_block_addr_gen
   import mem_rd_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic              i_advance,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W-1:0] i_stride,
   input  logic [DIM_W-1:0]  i_cols_m1,
   input  logic [DIM_W-1:0]  i_rows_m1,
   output logic [ADDR_W-1:0] o_next_addr,
   output logic              o_last
);

   logic [DIM_W-1:0]  r_col;
   logic [DIM_W-1:0]  r_row;
   logic [DIM_W-1:0]  r_cols_m1;
   logic [DIM_W-1:0]  r_rows_m1;
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_stride;

   // Latch block geometry on load and step col/row/row-base on each advance
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col      <= {DIM_W{1'b0}};
         r_row      <= {DIM_W{1'b0}};
         r_cols_m1  <= {DIM_W{1'b0}};
         r_rows_m1  <= {DIM_W{1'b0}};
         r_row_base <= {ADDR_W{1'b0}};
         r_stride   <= {ADDR_W{1'b0}};
      end else if (i_load) begin
         r_col      <= {DIM_W{1'b0}};
         r_row      <= {DIM_W{1'b0}};
         r_cols_m1  <= i_cols_m1;
         r_rows_m1  <= i_rows_m1;
         r_row_base <= i_base;
         r_stride   <= i_stride;
      end else if (i_advance) begin
         if (r_col < r_cols_m1) begin
            r_col <= r_col + 4'd1;
         end else begin
            r_col      <= {DIM_W{1'b0}};
            r_row      <= r_row + 4'd1;
            r_row_base <= r_row_base + r_stride;
         end
      end
   end

   // Next address: the adjacent byte within a row, or the next row start (modulo 2^ADDR_W)
   always_comb begin
      o_next_addr = r_row_base + r_stride;
      if (r_col < r_cols_m1) begin
         o_next_addr = r_row_base + ADDR_W'(r_col) + ADDR_W'(1'b1);
      end else begin
         o_next_addr = r_row_base + r_stride;
      end
   end

   assign o_last = (r_col == r_cols_m1) && (r_row == r_rows_m1);

endmodule

// File: rtl/mem_block_reader.sv
// Block reader for a byte-wide memory bank. It fetches a 2-D block in raster
// order and returns the bytes on a valid/ready stream that carries a last flag.
// The bank read is combinational. Each byte is captured in the output register
// on the same edge that advances the bank address.
module mem_block_reader
   import mem_rd_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [ADDR_W-1:0] Stride,
   input  logic [DIM_W-1:0]  ColsM1,
   input  logic [DIM_W-1:0]  RowsM1,
   output logic [ADDR_W-1:0] Address,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [DATA_W-1:0] ReadData,
   output logic [DATA_W-1:0] OutData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              OutLast,
   output logic              Busy,
   output logic              Done
);

   rd_state_e         r_state;
   rd_state_e         w_state_next;
   logic [ADDR_W-1:0] r_address;
   logic              r_mem_read;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_out_last;
   logic              r_busy;
   logic              r_done;

   logic              w_slot_free;
   logic              w_load;
   logic              w_capture;
   logic              w_drain_ack;
   logic [ADDR_W-1:0] w_gen_next;
   logic              w_gen_last;

   assign w_slot_free = !r_out_valid || OutReady;

   mem_block_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_clk       (Clk),
      .i_rst       (Rst),
      .i_load      (w_load),
      .i_advance   (w_capture),
      .i_base      (BaseAddr),
      .i_stride    (Stride),
      .i_cols_m1   (ColsM1),
      .i_rows_m1   (RowsM1),
      .o_next_addr (w_gen_next),
      .o_last      (w_gen_last)
   );

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: start in IDLE, leave READ on the last capture, leave DRAIN on acceptance
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (Start) w_state_next = READ;
            else       w_state_next = IDLE;
         end
         READ: begin
            if (w_slot_free && w_gen_last) w_state_next = DRAIN;
            else                           w_state_next = READ;
         end
         DRAIN: begin
            if (r_out_valid && OutReady) w_state_next = IDLE;
            else                         w_state_next = DRAIN;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Output decode: which datapath action the current state takes on this edge
   always_comb begin
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_drain_ack = 1'b0;
      case (r_state)
         IDLE:    w_load      = Start;
         READ:    w_capture   = w_slot_free;
         DRAIN:   w_drain_ack = r_out_valid && OutReady;
         default: w_load      = 1'b0;
      endcase
   end

   // Registered bank interface, output stream and status flags
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_address   <= {ADDR_W{1'b0}};
         r_mem_read  <= 1'b0;
         r_out_data  <= {DATA_W{1'b0}};
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_address  <= BaseAddr;
            r_mem_read <= 1'b1;
            r_busy     <= 1'b1;
         end
         if (w_capture) begin
            r_out_data  <= ReadData;
            r_out_valid <= 1'b1;
            r_out_last  <= w_gen_last;
            if (w_gen_last) r_mem_read <= 1'b0;
            else            r_address  <= w_gen_next;
         end
         if (w_drain_ack) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
         end
      end
   end

   assign Address  = r_address;
   assign MemRead  = r_mem_read;
   assign MemWrite = 1'b0;
   assign OutData  = r_out_data;
   assign OutValid = r_out_valid;
   assign OutLast  = r_out_last;
   assign Busy     = r_busy;
   assign Done     = r_done;

endmodule

// File: doc/mem_block_reader.md
# mem_block_reader

Initiator for the byte-wide data-memory banks: walks a 2-D block (up to 16×16 bytes, arbitrary row stride) inside one 256-byte bank and drives the bank's address and read-enable. Returns the bytes in raster order on a valid/ready stream with a last-beat flag. Sits between the bank and the per-bank compute datapath. Supplies bytes at one per cycle when the consumer is always ready.

## Interface
Parameters:
- ADDR_W, 8, bank address width.
- DATA_W, 8, bank data width.

Ports:
- Clk  in  1  single clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- BaseAddr  in  ADDR_W  address of block element (0,0).
- Stride  in  ADDR_W  address delta between consecutive row starts.
- ColsM1  in  4  columns minus one (1..16 columns).
- RowsM1  in  4  rows minus one (1..16 rows).
- Address  out  ADDR_W  bank address; registered.
- MemRead  out  1  bank read enable; registered.
- MemWrite  out  1  bank write enable; constant 0.
- ReadData  in  DATA_W  bank read data; combinational from Address when MemRead=1.
- OutData  out  DATA_W  captured byte.
- OutValid  out  1  OutData valid.
- OutReady  in  1  consumer accepts when OutValid&&OutReady.
- OutLast  out  1  marks final byte of the block; qualified by OutValid.
- Busy  out  1  high in READ and DRAIN.
- Done  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- Reset values: state IDLE; Address=0, MemRead=0, MemWrite=0, OutData=0, OutValid=0, OutLast=0, Busy=0, Done=0; all counters 0.
- IDLE, Start=1: latch BaseAddr, Stride, ColsM1, RowsM1; RowBase=BaseAddr; col=0, row=0; Address=BaseAddr; MemRead=1; go to READ.
- READ: the output slot is free when !OutValid || OutReady. On each free-slot edge:
  - OutData<=ReadData; OutValid<=1.
  - OutLast<=(col==ColsM1 && row==RowsM1).
  - Advance the element.
- Element advance:
  - col<ColsM1: col+1, Address+1.
  - Else: col=0, row+1, RowBase=RowBase+Stride, Address=new RowBase.
- All address arithmetic is modulo 2^ADDR_W; wrap past 255 to 0 is legal and silent.
- On capturing the last element: MemRead<=0, go to DRAIN. Address holds its last value.
- READ with slot not free: hold Address, counters, OutData, OutValid and OutLast unchanged. MemRead stays 1.
- DRAIN: when OutValid&&OutReady, clear OutValid and OutLast, assert Done for one cycle, go to IDLE.
- Start is ignored outside IDLE. Start on the same edge as Done is not accepted; it must be re-presented in IDLE.
- Rst at any time, including mid-block, forces reset values on the next edge. No partial stream resumes.
- Consumer rule: OutData, OutValid and OutLast hold stable while OutValid&&!OutReady.

## Timing
- Start sampled at edge k: Busy=1, MemRead=1, Address=BaseAddr after edge k.
- First OutValid after edge k+1.
- With OutReady held high, one byte per cycle. For N=(ColsM1+1)(RowsM1+1) bytes, the last byte is valid after edge k+N.
- Done is high after edge k+N+1; Busy=0 in that same cycle.
- The next Start is accepted at edge k+N+2 at the earliest.
- Each OutReady-low cycle adds exactly one cycle of latency. No byte is dropped or duplicated.
- Row transition costs no bubble.

## Structure
- Package mem_rd_pkg holds:
  - state enum {IDLE, READ, DRAIN}.
  - ADDR_W/DATA_W defaults.
  - The 4-bit dimension width constant.
- One sub-module: mem_block_addr_gen. It holds col, row and RowBase, outputs the next Address, and flags the last element. The top holds the FSM and the output register.

## Test plan
- BaseAddr=0x10, Stride=0x10, ColsM1=3, RowsM1=1, OutReady=1 -> bytes from 0x10-0x13 then 0x20-0x23. OutLast only on the 0x23 byte. Done after edge k+9.
- BaseAddr=0xFE, Stride=0x01, ColsM1=3, RowsM1=0 -> addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
- 16×16 block, BaseAddr=0, Stride=16, with OutReady toggling 1,0,0,1 pseudo-randomly -> exactly 256 bytes equal to mem[0..255] in order. Outputs stable while stalled.
- Start pulsed during READ with different BaseAddr -> ignored; the original stream completes unchanged.
- Rst asserted on the 5th beat of a 4×4 block -> next cycle all outputs at reset values and state IDLE. A fresh Start then runs a full block correctly.
- ColsM1=0, RowsM1=0, BaseAddr=0x7F -> single byte with OutLast=1. Done one cycle after acceptance. MemWrite is 0 throughout.
